// File: rtl/led_pkg.sv
// Package for the LED breathing block.
// Holds the ramp phase encoding and its width. The top-level design and the
// testbench both import it.
package led_pkg;

  localparam int PHASE_W = 2;

  // Ramp phase encoding. The numeric codes appear directly on the PHASE port.
  typedef enum logic [PHASE_W-1:0] {
    UP      = 2'd0,
    HOLD_HI = 2'd1,
    DOWN    = 2'd2,
    HOLD_LO = 2'd3
  } phase_t;

endpackage

// File: rtl/pwm_gen.sv
// PWM generator with a frame-synchronous duty shadow.
// Ports:
//   CLK    - clock, rising edge
//   RESETN - asynchronous active-low reset
//   EN     - run enable; when low the counter and shadow freeze and LED drops
//   DUTY   - target duty, sampled only at the frame boundary (pwm_cnt == MAX)
//   LED    - registered PWM output, high while pwm_cnt < act
module pwm_gen #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             EN,
  input  logic [WIDTH-1:0] DUTY,
  output logic             LED
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic [WIDTH-1:0] pwm_cnt;
  logic [WIDTH-1:0] act;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pwm_cnt <= '0;
      act     <= '0;
      LED     <= 1'b0;
    end else begin
      // The compare uses the act value of the current frame. On the wrap
      // cycle, pwm_cnt == MAX is never below act, so a freshly loaded act
      // cannot create a glitch pulse.
      LED <= EN && (pwm_cnt < act);
      if (EN) begin
        pwm_cnt <= pwm_cnt + 1'b1;
        if (pwm_cnt == MAX) begin
          act <= DUTY;
        end
      end
    end
  end

endmodule

// File: rtl/led_breathe.sv
// LED "breathing" controller.
// The duty ramps up once per TICK until it reaches MAX. It then holds for HOLD
// TICKs, ramps down to 0 and holds for HOLD TICKs again, and the cycle repeats.
// The duty drives a pwm_gen instance.
// Ports:
//   CLK    - clock, rising edge
//   RESETN - asynchronous active-low reset
//   TICK   - single-cycle ramp-step strobe (counter carry-out)
//   EN     - run enable; when low all state freezes, TICKs are ignored and LED = 0
//   LED    - registered PWM output
//   DUTY   - current ramp value (target duty)
//   PHASE  - ramp phase: 0 UP, 1 HOLD_HI, 2 DOWN, 3 HOLD_LO
module led_breathe
  import led_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int HOLD  = 4
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               TICK,
  input  logic               EN,
  output logic               LED,
  output logic [WIDTH-1:0]   DUTY,
  output logic [PHASE_W-1:0] PHASE
);

  localparam logic [WIDTH-1:0] MAX       = '1;
  localparam logic [WIDTH-1:0] MAX_M1    = MAX - 1'b1;
  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [7:0]       HOLD_LAST = 8'(HOLD - 1);

  phase_t     phase;
  logic [7:0] hold_cnt;
  logic       step;

  assign step  = TICK & EN;
  assign PHASE = phase;

  // The phase changes in the same step that produces the end value.
  // Because of this, DUTY stops at MAX or 0 and cannot wrap.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      phase    <= UP;
      DUTY     <= '0;
      hold_cnt <= '0;
    end else if (step) begin
      case (phase)
        UP: begin
          DUTY <= DUTY + 1'b1;
          if (DUTY == MAX_M1) begin
            phase    <= HOLD_HI;
            hold_cnt <= '0;
          end
        end
        HOLD_HI: begin
          if (hold_cnt == HOLD_LAST) begin
            phase    <= DOWN;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        DOWN: begin
          DUTY <= DUTY - 1'b1;
          if (DUTY == ONE) begin
            phase    <= HOLD_LO;
            hold_cnt <= '0;
          end
        end
        HOLD_LO: begin
          if (hold_cnt == HOLD_LAST) begin
            phase    <= UP;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: phase <= UP;
      endcase
    end
  end

  pwm_gen #(
    .WIDTH(WIDTH)
  ) u_pwm (
    .CLK   (CLK),
    .RESETN(RESETN),
    .EN    (EN),
    .DUTY  (DUTY),
    .LED   (LED)
  );

endmodule

// File: tb/tb_led_breathe.sv
// Directed testbench for led_breathe.
// u_dut runs with WIDTH=4 and HOLD=2. u_big runs with the default parameters.
module tb_led_breathe;

  logic       CLK    = 1'b0;
  logic       RESETN = 1'b0;
  logic       TICK   = 1'b0;
  logic       EN     = 1'b0;
  logic       TICK2  = 1'b0;
  logic       EN2    = 1'b0;
  logic       LED, LED2;
  logic [3:0] DUTY;
  logic [7:0] DUTY2;
  logic [1:0] PHASE, PHASE2;

  int n_vec = 0;
  int n_err = 0;

  // Expected position of u_dut's PWM counter. It advances on every edge with
  // EN high and is cleared by reset.
  logic [3:0] fc = 4'd0;

  always #5 CLK = ~CLK;

  led_breathe #(.WIDTH(4), .HOLD(2)) u_dut (
    .CLK(CLK), .RESETN(RESETN), .TICK(TICK), .EN(EN),
    .LED(LED), .DUTY(DUTY), .PHASE(PHASE)
  );

  led_breathe u_big (
    .CLK(CLK), .RESETN(RESETN), .TICK(TICK2), .EN(EN2),
    .LED(LED2), .DUTY(DUTY2), .PHASE(PHASE2)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then wait 1 time unit before returning.
  task automatic step();
    logic en_s;
    en_s = EN;
    @(posedge CLK);
    if (!RESETN) fc = 4'd0;
    else if (en_s) fc = fc + 4'd1;
    #1;
  endtask

  task automatic pulse();
    TICK = 1'b1;
    step();
    TICK = 1'b0;
  endtask

  task automatic wait_fc(input logic [3:0] v);
    int n;
    n = 0;
    step();
    while (fc != v && n < 40) begin
      step();
      n++;
    end
    chk("wait_frame", int'(fc), int'(v));
  endtask

  task automatic count_led(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (LED) hi++;
    end
  endtask

  // Expected {PHASE, DUTY} after the k-th TICK of a period (k = 1..34).
  function automatic logic [5:0] exp_ph_du(input int k);
    if (k < 15)  return {2'd0, 4'(k)};
    if (k <= 16) return {2'd1, 4'd15};
    if (k == 17) return {2'd2, 4'd15};
    if (k < 32)  return {2'd2, 4'(32 - k)};
    if (k < 34)  return {2'd3, 4'd0};
    return {2'd0, 4'd0};
  endfunction

  initial begin
    int hi;
    int peak;
    int jumps;
    logic [7:0] prev;

    // Initial reset
    step(); step(); step();
    chk("rst_led",   int'(LED),   0);
    chk("rst_duty",  int'(DUTY),  0);
    chk("rst_phase", int'(PHASE), 0);
    chk("rst_big",   int'({PHASE2, DUTY2}), 0);
    #3 RESETN = 1'b1;
    EN = 1'b1;
    count_led(64, hi);
    chk("idle_led_highs", hi, 0);

    // Ramp up: 15 TICKs spaced 20 cycles apart
    for (int k = 1; k <= 15; k++) begin
      pulse();
      chk("ramp_up", int'({PHASE, DUTY}), int'(exp_ph_du(k)));
      for (int g = 0; g < 19; g++) step();
    end
    wait_fc(4'd0);
    count_led(16, hi);
    chk("full_frame_highs", hi, 15);

    // Finish the first period, then run two complete periods
    for (int k = 16; k <= 34; k++) begin
      pulse();
      chk("period0", int'({PHASE, DUTY}), int'(exp_ph_du(k)));
      step(); step();
    end
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 34; k++) begin
        pulse();
        chk("period_rep", int'({PHASE, DUTY}), int'(exp_ph_du(k)));
        step(); step();
      end
    end

    // TICK arrives on the same cycle as the frame boundary
    for (int k = 1; k <= 3; k++) begin
      pulse();
      step();
    end
    chk("coll_pre_duty", int'(DUTY), 3);
    wait_fc(4'd15);
    pulse();
    count_led(16, hi);
    chk("coll_frame0_highs", hi, 3);
    chk("coll_duty", int'(DUTY), 4);
    count_led(16, hi);
    chk("coll_frame1_highs", hi, 4);

    // Enable gating
    for (int k = 0; k < 3; k++) begin
      pulse();
      step();
    end
    chk("gate_pre_duty", int'(DUTY), 7);
    wait_fc(4'd0);
    step();
    chk("gate_led_before", int'(LED), 1);
    EN = 1'b0;
    step();
    chk("gate_led_off", int'(LED), 0);
    hi = 0;
    for (int k = 0; k < 5; k++) begin
      pulse();
      if (LED) hi++;
      step();
      if (LED) hi++;
    end
    chk("gate_duty_frozen",  int'(DUTY),  7);
    chk("gate_phase_frozen", int'(PHASE), 0);
    chk("gate_led_highs",    hi, 0);
    EN = 1'b1;
    step(); step(); step();
    pulse();
    chk("gate_resume_duty", int'(DUTY), 8);

    // Reset mid-operation, asserted away from the clock edge
    wait_fc(4'd0);
    step();
    chk("midrst_led_before", int'(LED), 1);
    #3 RESETN = 1'b0;
    #1;
    chk("midrst_led",   int'(LED),   0);
    chk("midrst_duty",  int'(DUTY),  0);
    chk("midrst_phase", int'(PHASE), 0);
    step(); step();
    #3 RESETN = 1'b1;
    count_led(64, hi);
    chk("post_rst_led_highs", hi, 0);
    pulse();
    chk("post_rst_first_tick", int'(DUTY), 1);

    // Default parameters with TICK held high every cycle
    EN2   = 1'b1;
    TICK2 = 1'b1;
    peak  = 0;
    jumps = 0;
    prev  = DUTY2;
    for (int i = 1; i <= 518; i++) begin
      step();
      if (int'(DUTY2) > peak) peak = int'(DUTY2);
      if (int'(DUTY2) - int'(prev) > 1 || int'(prev) - int'(DUTY2) > 1) jumps++;
      prev = DUTY2;
      if (i == 255) chk("big_t255", int'({PHASE2, DUTY2}), int'({2'd1, 8'd255}));
      if (i == 259) chk("big_t259", int'({PHASE2, DUTY2}), int'({2'd2, 8'd255}));
      if (i == 260) chk("big_t260", int'({PHASE2, DUTY2}), int'({2'd2, 8'd254}));
      if (i == 514) chk("big_t514", int'({PHASE2, DUTY2}), int'({2'd3, 8'd0}));
      if (i == 517) chk("big_t517", int'({PHASE2, DUTY2}), int'({2'd3, 8'd0}));
      if (i == 518) chk("big_t518", int'({PHASE2, DUTY2}), int'({2'd0, 8'd0}));
    end
    TICK2 = 1'b0;
    chk("big_peak",  peak,  255);
    chk("big_jumps", jumps, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_breathe.md
# led_breathe

Downstream consumer of the free-running prescale counter: takes the counter's one-cycle carry-out strobe as a ramp tick and drives an LED with a "breathing" PWM waveform. The duty ramps up, holds at full, ramps down and holds at off, then repeats. It sits between the counter stage and the board LED pin (e.g. `D1`) in the top-level `main`.

## Interface

Parameters:
- `WIDTH`, 8: PWM resolution in bits. MAX = 2^WIDTH−1. Legal range 2..16.
- `HOLD`, 4: number of TICKs spent at each extreme. Legal range 1..255.

Ports:
- `CLK`, input, 1 bit: sole clock, rising edge.
- `RESETN`, input, 1 bit: asynchronous, active-low reset.
- `TICK`, input, 1 bit: one-cycle ramp-step strobe. Driven by the counter `COUT`.
- `EN`, input, 1 bit: run enable.
- `LED`, output, 1 bit: registered PWM output.
- `DUTY`, output, `WIDTH` bits: current target duty (ramp value).
- `PHASE`, output, 2 bits: ramp state encoding.

## Operation

- **PWM counter** `pwm_cnt` (`WIDTH` bits):
  - Increments every `CLK` while `EN`=1.
  - Wraps from MAX to 0.
- **Active duty** `act`:
  - A shadow copy of target `DUTY`.
  - Loaded only in the cycle where `pwm_cnt`==MAX (frame boundary), so no mid-frame glitch.
- **LED output**: `LED` <= `EN` && (`pwm_cnt` < `act`).
  - `act`=0 gives always off.
  - `act`=MAX gives high for MAX of every 2^WIDTH cycles.
- **Ramp FSM**, stepped only on `TICK`=1 with `EN`=1. Encoding: UP=0, HOLD_HI=1, DOWN=2, HOLD_LO=3.
  - UP: `DUTY` += 1. If the new value is MAX, go to HOLD_HI and clear `hold_cnt`.
  - HOLD_HI: `hold_cnt` += 1. When `hold_cnt`==HOLD−1, go to DOWN and clear `hold_cnt`.
  - DOWN: `DUTY` −= 1. If the new value is 0, go to HOLD_LO and clear `hold_cnt`.
  - HOLD_LO: same as HOLD_HI, then go to UP.
- **Arithmetic**: `DUTY` never wraps; it is bounded to 0..MAX by the FSM. `hold_cnt` is 8 bits.
- **Period**: 2·MAX + 2·HOLD TICKs. For the defaults that is 518.
- **`EN`=0**:
  - `LED` is 0 on the next edge.
  - `pwm_cnt`, `act`, FSM, `DUTY` and `hold_cnt` are frozen; TICKs are ignored.
  - When `EN` returns to 1, operation resumes from the frozen state.

## Timing

- **Reset values** (asynchronous on `RESETN`=0, held while low):
  - `LED`=0, `DUTY`=0, `PHASE`=0 (UP).
  - `pwm_cnt`=0, `act`=0, `hold_cnt`=0.
- **Reset mid-operation**: all state returns to the reset values immediately. The first post-reset TICK moves `DUTY` to 1.
- **TICK to DUTY/PHASE latency**: 1 cycle (visible after the edge that samples `TICK`).
- **DUTY to LED effect**: takes hold at the next frame boundary, then `LED` follows by 1 cycle (registered compare).
- **TICK coinciding with `pwm_cnt`==MAX**: `act` loads the pre-TICK `DUTY`. The new value applies one frame later.
- **TICK held high for N cycles**: counted as N steps. Callers must supply single-cycle strobes.

## Structure

- **Package `led_pkg`**:
  - `phase_t` enum (UP, HOLD_HI, DOWN, HOLD_LO with codes 0..3).
  - `PHASE_W`=2 constant.
- **Sub-module `pwm_gen`**:
  - Parameter `WIDTH`.
  - Contents: `pwm_cnt`, shadow `act` load at wrap, registered compare.
  - Ports: `CLK`, `RESETN`, `EN`, `DUTY`, `LED`.
- **Top `led_breathe`**: ramp FSM and `hold_cnt`; instantiates one `pwm_gen`.

## Test plan

All scenarios use `WIDTH`=4 (MAX=15) and `HOLD`=2 unless stated otherwise.

- **Reset**: assert `RESETN`=0 mid-clock → `LED`=0, `DUTY`=0, `PHASE`=0 immediately. Release, run 64 cycles with `EN`=1 and no TICK → `LED` never 1.
- **Ramp up**: 15 single-cycle TICKs spaced 20 cycles apart → `DUTY` 1..15, `PHASE`=1 after the 15th. In the first full frame after the next wrap, `LED`=1 for exactly 15 of 16 cycles.
- **Full cycle**: continue with 2 TICKs → `PHASE`=2; 15 TICKs → `DUTY`=0, `PHASE`=3; 2 TICKs → `PHASE`=0. Total 34 TICKs per period. Repeat twice with identical `DUTY`/`PHASE` trace.
- **Frame-boundary collision**: with `DUTY`=3, pulse TICK in the cycle `pwm_cnt`==15 → current frame `LED` high 3 cycles, next frame high 4 cycles, `DUTY`=4.
- **Enable gating**: drop `EN` at `DUTY`=7 → `LED`=0 next cycle. Pulse 5 TICKs → `DUTY` stays 7. Raise `EN` → ramp resumes at 8 on the next TICK.
- **Default parameters**: `WIDTH`=8, `HOLD`=4, TICK every cycle → `PHASE` returns to 0 after 518 TICKs; `DUTY` peaks at 255 and never wraps.
